stream_generator_p: RTL and testbench

STREAM_GENERATOR_P -- requirements
Module: stream_generator_p

---
 rtl/stream_generator_p.sv | 218 +++++++++++++++++++++
 tb/tb_stream_generator_p.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_generator_p.sv
// ---------------------------------------------------------------------------
// stream_generator_p
//
// Generates a paced stream of pattern words with a valid/ready handshake.
// Every PERIOD clock cycles, while running, a generation event occurs. The
// event loads the current pattern into the output register, unless a
// previous word is still waiting for the sink. In that case the event is
// dropped and the sticky overrun flag is raised. A run ends after burst_len
// words, or runs on indefinitely when burst_len is 0.
//
// Optional feature: define STREAM_GEN_DROP_CNT_EN to add a 16-bit saturating
// drop_cnt output that counts dropped events.
//
// Parameters
//   DATA_W  width of generated word (8..64)
//   PERIOD  cycles between generation events (2..65535)
//   SEED    initial pattern value (truncated to DATA_W)
//   TAPS    Galois LFSR feedback mask (truncated to DATA_W)
//
// Ports
//   clk        clock, rising edge
//   n_rst      synchronous active-low reset
//   enable     run request (level)
//   mode       0 increment, 1 LFSR, 2 walking-one, 3 constant SEED
//   burst_len  words per run, 0 = continuous
//   data       generated word
//   valid      data holds a word not yet accepted
//   ready      sink accepts data when valid & ready
//   overrun    sticky: at least one event was dropped during this run
//   done       burst complete
//   drop_cnt   dropped-event count (only with STREAM_GEN_DROP_CNT_EN)
// ---------------------------------------------------------------------------
module stream_generator_p #(
    parameter int          DATA_W = 32,
    parameter int          PERIOD = 18,
    parameter logic [63:0] SEED   = 64'h0000_0000_FAFB_FCFD,
    parameter logic [63:0] TAPS   = 64'h0000_0000_8020_0003
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [15:0]       burst_len,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic              done
`ifdef STREAM_GEN_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam logic [DATA_W-1:0] SEED_W    = SEED[DATA_W-1:0];
    localparam logic [DATA_W-1:0] TAPS_W    = TAPS[DATA_W-1:0];
    localparam logic [DATA_W-1:0] ONE_W     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       LAST_TICK = 16'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [15:0]       ticks_reg;
    logic [15:0]       words_reg;
    logic [DATA_W-1:0] pattern_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              overrun_reg;
    logic              done_reg;
    logic [1:0]        mode_reg;
    logic [15:0]       blen_reg;
`ifdef STREAM_GEN_DROP_CNT_EN
    logic [15:0]       drop_cnt_reg;
`endif

    logic [DATA_W-1:0] start_next;
    logic [DATA_W-1:0] pattern_next;
    logic [DATA_W-1:0] lfsr_next;
    logic [DATA_W-1:0] rot_next;
    logic              event_now;
    logic              can_load;
    logic              last_word;

    // Per-bit next-state for the Galois LFSR (shift right, XOR taps when the
    // shifted-out bit is 1) and for the walking-one rotate-left.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bits
            if (gi == DATA_W - 1) begin : g_msb
                assign lfsr_next[gi] = pattern_reg[0] & TAPS_W[gi];
            end else begin : g_low
                assign lfsr_next[gi] = pattern_reg[gi+1] ^ (pattern_reg[0] & TAPS_W[gi]);
            end
            assign rot_next[gi] = pattern_reg[(gi + DATA_W - 1) % DATA_W];
        end
    endgenerate

    // Start value depends on the mode presented at the IDLE->RUN edge. An
    // all-zero LFSR would lock up, so mode 1 substitutes 1 for a zero seed.
    always_comb begin
        start_next = SEED_W;
        if (mode == 2'd2) begin
            start_next = ONE_W;
        end else if (mode == 2'd1 && SEED_W == '0) begin
            start_next = ONE_W;
        end
    end

    always_comb begin
        pattern_next = pattern_reg;
        case (mode_reg)
            2'd0:    pattern_next = pattern_reg + ONE_W;
            2'd1:    pattern_next = lfsr_next;
            2'd2:    pattern_next = rot_next;
            default: pattern_next = pattern_reg;
        endcase
    end

    assign event_now = (state_reg == RUN) && (ticks_reg == LAST_TICK);
    assign can_load  = !valid_reg || ready;
    assign last_word = (blen_reg != 16'd0) && ((words_reg + 16'd1) == blen_reg);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            ticks_reg    <= '0;
            words_reg    <= '0;
            pattern_reg  <= SEED_W;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
            done_reg     <= 1'b0;
            mode_reg     <= 2'd0;
            blen_reg     <= '0;
`ifdef STREAM_GEN_DROP_CNT_EN
            drop_cnt_reg <= '0;
`endif
        end else begin
            // Handshake retires the pending word; a load below overrides this.
            if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg    <= RUN;
                        ticks_reg    <= '0;
                        words_reg    <= '0;
                        pattern_reg  <= start_next;
                        mode_reg     <= mode;
                        blen_reg     <= burst_len;
                        overrun_reg  <= 1'b0;
`ifdef STREAM_GEN_DROP_CNT_EN
                        drop_cnt_reg <= '0;
`endif
                    end
                end

                RUN: begin
                    if (event_now) begin
                        ticks_reg <= '0;
                        if (can_load) begin
                            data_reg    <= pattern_reg;
                            valid_reg   <= 1'b1;
                            pattern_reg <= pattern_next;
                            words_reg   <= words_reg + 16'd1;
                            if (last_word) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            overrun_reg <= 1'b1;
`ifdef STREAM_GEN_DROP_CNT_EN
                            if (drop_cnt_reg != 16'hFFFF) begin
                                drop_cnt_reg <= drop_cnt_reg + 16'd1;
                            end
`endif
                        end
                    end else begin
                        ticks_reg <= ticks_reg + 16'd1;
                    end
                    // Dropping enable still lets a coincident event complete
                    // above; this later assignment only redirects the state.
                    if (!enable) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end

                DONE: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign data    = data_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;
    assign done    = done_reg;
`ifdef STREAM_GEN_DROP_CNT_EN
    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_stream_generator_p.sv
// ---------------------------------------------------------------------------
// tb_stream_generator_p
//
// Self-checking bench for stream_generator_p. Three instances cover the
// default configuration, an 8-bit build seeded with FE (wrap and walking-one
// cases), and a zero-seed build (LFSR zero-seed substitution). Expected
// words are queued per instance when a run is started. A negedge monitor
// pops and compares a word on every accepted handshake.
// ---------------------------------------------------------------------------
module tb_stream_generator_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic [2:0]  en;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic        ready;

    logic [31:0] data0;
    logic [7:0]  data1;
    logic [31:0] data2;
    logic [2:0]  vld;
    logic [2:0]  ovr;
    logic [2:0]  dn;
`ifdef STREAM_GEN_DROP_CNT_EN
    logic [15:0] drop0;
    logic [15:0] drop1;
    logic [15:0] drop2;
`endif

    stream_generator_p u0 (
        .clk(clk), .n_rst(n_rst), .enable(en[0]), .mode(mode), .burst_len(burst_len),
        .data(data0), .valid(vld[0]), .ready(ready), .overrun(ovr[0]), .done(dn[0])
`ifdef STREAM_GEN_DROP_CNT_EN
        , .drop_cnt(drop0)
`endif
    );

    stream_generator_p #(.DATA_W(8), .PERIOD(5), .SEED(64'hFFFF_FFFE)) u1 (
        .clk(clk), .n_rst(n_rst), .enable(en[1]), .mode(mode), .burst_len(burst_len),
        .data(data1), .valid(vld[1]), .ready(ready), .overrun(ovr[1]), .done(dn[1])
`ifdef STREAM_GEN_DROP_CNT_EN
        , .drop_cnt(drop1)
`endif
    );

    stream_generator_p #(.DATA_W(32), .PERIOD(5), .SEED(64'h0)) u2 (
        .clk(clk), .n_rst(n_rst), .enable(en[2]), .mode(mode), .burst_len(burst_len),
        .data(data2), .valid(vld[2]), .ready(ready), .overrun(ovr[2]), .done(dn[2])
`ifdef STREAM_GEN_DROP_CNT_EN
        , .drop_cnt(drop2)
`endif
    );

    logic [63:0] dat [3];
    assign dat[0] = {32'h0, data0};
    assign dat[1] = {56'h0, data1};
    assign dat[2] = {32'h0, data2};

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] q [3][$];
    logic [63:0] mon_exp;

    typedef struct {
        int          sel;
        logic [1:0]  mode;
        logic [15:0] blen;
        int          nwords;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference pattern advance, computed on a 64-bit value masked to width.
    function automatic logic [63:0] model_adv(input int w, input logic [1:0] m,
                                              input logic [63:0] p);
        logic [63:0] mask;
        logic [63:0] taps;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        taps = 64'h8020_0003 & mask;
        case (m)
            2'd0:    return (p + 64'd1) & mask;
            2'd1:    return ((p >> 1) ^ (p[0] ? taps : 64'd0)) & mask;
            2'd2:    return ((p << 1) | (p >> (w - 1))) & mask;
            default: return p;
        endcase
    endfunction

    // Scoreboard monitor: a word is consumed on the edge after a negedge
    // that sees valid & ready with reset released.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (n_rst && vld[i] && ready) begin
                if (q[i].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word dut%0d: got %0h, required no word", i, dat[i]);
                end else begin
                    mon_exp = q[i].pop_front();
                    chk($sformatf("word_dut%0d", i), dat[i], mon_exp);
                end
            end
        end
    end

    task automatic drain(input int sel, input int limit, input string name);
        int g;
        g = 0;
        while (q[sel].size() != 0 && g < limit) begin
            tick();
            g++;
        end
        if (q[sel].size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout with %0d words outstanding, required 0", name, q[sel].size());
            q[sel].delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          per;
        int          w;
        logic [63:0] p;
        per = (v.sel == 0) ? 18 : 5;
        w   = (v.sel == 1) ? 8 : 32;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        ready = 1'b1;
        mode = v.mode;
        burst_len = v.blen;
        en[v.sel] = 1'b1;
        q[v.sel].push_back(v.e0);
        if (v.nwords > 1) q[v.sel].push_back(v.e1);
        p = v.e1;
        for (int k = 2; k < v.nwords; k++) begin
            p = model_adv(w, v.mode, p);
            q[v.sel].push_back(p);
        end
        tick();
        // Inputs changed after the start edge must not affect this run.
        mode = ~v.mode;
        burst_len = v.blen + 16'd3;
        drain(v.sel, 200 * per, $sformatf("vec%0d_drain", idx));
        if (v.blen != 16'd0) begin
            tick();
            chk($sformatf("vec%0d_done_set", idx), 64'(dn[v.sel]), 64'd1);
            repeat (3 * per) tick();
            chk($sformatf("vec%0d_done_hold", idx), 64'(dn[v.sel]), 64'd1);
            en[v.sel] = 1'b0;
            repeat (2) tick();
            chk($sformatf("vec%0d_done_clear", idx), 64'(dn[v.sel]), 64'd0);
        end else begin
            en[v.sel] = 1'b0;
            repeat (2) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vt[0] = '{0, 2'd0, 16'd0, 3, 64'hFAFB_FCFD, 64'hFAFB_FCFE};
        vt[1] = '{0, 2'd1, 16'd3, 3, 64'hFAFB_FCFD, 64'hFD5D_FE7D};
        vt[2] = '{0, 2'd2, 16'd2, 2, 64'h1,         64'h2};
        vt[3] = '{0, 2'd3, 16'd3, 3, 64'hFAFB_FCFD, 64'hFAFB_FCFD};
        vt[4] = '{1, 2'd0, 16'd4, 4, 64'hFE,        64'hFF};
        vt[5] = '{1, 2'd2, 16'd9, 9, 64'h01,        64'h02};
        vt[6] = '{2, 2'd1, 16'd0, 3, 64'h1,         64'h8020_0003};
        vt[7] = '{1, 2'd1, 16'd5, 5, 64'hFE,        64'h7F};
        vt[8] = '{2, 2'd0, 16'd2, 2, 64'h0,         64'h1};
        vt[9] = '{2, 2'd3, 16'd2, 2, 64'h0,         64'h0};

        n_rst = 1'b0;
        en = 3'b000;
        mode = 2'd0;
        burst_len = 16'd0;
        ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 64'(vld), 64'd0);
        chk("rst_done", 64'(dn), 64'd0);
        chk("rst_overrun", 64'(ovr), 64'd0);
        chk("rst_data0", dat[0], 64'd0);
        chk("rst_data1", dat[1], 64'd0);
        n_rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], i);
        end

        // First valid exactly PERIOD cycles after the start edge, then
        // one word every PERIOD cycles.
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        ready = 1'b1;
        mode = 2'd0;
        burst_len = 16'd0;
        en[0] = 1'b1;
        q[0].push_back(64'hFAFB_FCFD);
        q[0].push_back(64'hFAFB_FCFE);
        tick();
        cyc = 0;
        while (!vld[0] && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("first_valid_latency", 64'(cyc), 64'd18);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!vld[0] && cyc < 100);
        chk("event_spacing", 64'(cyc), 64'd18);
        en[0] = 1'b0;
        drain(0, 100, "spacing_drain");
        repeat (2) tick();

        // Backpressure across three events: the first word is held, two
        // events are dropped, and the next load continues the sequence.
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        ready = 1'b0;
        mode = 2'd0;
        burst_len = 16'd0;
        en[0] = 1'b1;
        tick();
        repeat (20) tick();
        chk("hold_valid", 64'(vld[0]), 64'd1);
        chk("hold_data_early", dat[0], 64'hFAFB_FCFD);
        chk("hold_overrun_early", 64'(ovr[0]), 64'd0);
        repeat (40) tick();
        chk("hold_data_late", dat[0], 64'hFAFB_FCFD);
        chk("hold_overrun_late", 64'(ovr[0]), 64'd1);
`ifdef STREAM_GEN_DROP_CNT_EN
        chk("drop_cnt", 64'(drop0), 64'd2);
`endif
        q[0].push_back(64'hFAFB_FCFD);
        q[0].push_back(64'hFAFB_FCFE);
        ready = 1'b1;
        drain(0, 200, "backpressure_drain");
        chk("overrun_sticky", 64'(ovr[0]), 64'd1);
        en[0] = 1'b0;
        repeat (2) tick();

        // Reset mid-burst with a pending word.
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        ready = 1'b0;
        mode = 2'd0;
        burst_len = 16'd5;
        en[0] = 1'b1;
        repeat (21) tick();
        chk("midrst_pre_valid", 64'(vld[0]), 64'd1);
        n_rst = 1'b0;
        tick();
        chk("midrst_valid", 64'(vld[0]), 64'd0);
        chk("midrst_done", 64'(dn[0]), 64'd0);
        chk("midrst_data", dat[0], 64'd0);
        chk("midrst_overrun", 64'(ovr[0]), 64'd0);
        en[0] = 1'b0;
        n_rst = 1'b1;
        ready = 1'b1;
        repeat (25) tick();
        chk("midrst_idle_valid", 64'(vld[0]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
